// File: rtl/dbg_core_agent_if.sv
// Hub/core-facing signal bundle for the debug core agent.
// Latency: none, wires only.
// Backpressure: bp_valid/bp_ready and trace_valid/trace_ready handshakes.
interface dbg_core_agent_if #(
  parameter int TRACE_W = 128
);
  // run control
  logic               halt_req;
  logic               run_req;
  logic               step_req;
  logic               halt_ack;
  logic               step_ack;
  // breakpoint programming
  logic               bp_valid;
  logic               bp_ready;
  logic               bp_write;
  logic [7:0]         bp_index;
  logic [31:0]        bp_addr;
  logic [3:0]         bp_kind;
  logic               bp_enable;
  // trace output
  logic               trace_valid;
  logic               trace_ready;
  logic [TRACE_W-1:0] trace_data;
  // core side
  logic               core_hold;
  logic               core_quiesced;
  logic               retire_valid;
  logic [31:0]        retire_pc;
  logic               mem_valid;
  logic               mem_write;
  logic [31:0]        mem_addr;

  modport master (
    output halt_req, run_req, step_req,
    output bp_valid, bp_write, bp_index, bp_addr, bp_kind, bp_enable,
    output trace_ready,
    output core_quiesced, retire_valid, retire_pc, mem_valid, mem_write, mem_addr,
    input  halt_ack, step_ack, bp_ready, trace_valid, trace_data, core_hold
  );

  modport slave (
    input  halt_req, run_req, step_req,
    input  bp_valid, bp_write, bp_index, bp_addr, bp_kind, bp_enable,
    input  trace_ready,
    input  core_quiesced, retire_valid, retire_pc, mem_valid, mem_write, mem_addr,
    output halt_ack, step_ack, bp_ready, trace_valid, trace_data, core_hold
  );
endinterface

// File: rtl/dbg_core_agent.sv
// Core-side debug responder: halt/run/step FSM, breakpoint/watchpoint table, halt trace records.
// Latency: all outputs registered; core_hold rises one cycle after halt_req or a hit in RUN.
// Backpressure: bp always ready; one-entry trace buffer, records dropped with sticky overflow when full.
module dbg_core_agent #(
  parameter int BP_COUNT     = 4,
  parameter int TRACE_W      = 128,
  parameter int RESET_HALTED = 0
) (
  input logic          clk,
  input logic          rst,
  dbg_core_agent_if.slave dbg
);

  typedef enum logic [1:0] {S_RUN, S_HALT_PEND, S_HALTED, S_STEP} state_t;

  localparam state_t RST_STATE = (RESET_HALTED != 0) ? S_HALT_PEND : S_RUN;
  localparam logic   RST_HOLD  = (RESET_HALTED != 0);

  state_t state_q, state_nxt;

  // breakpoint table; kind keeps only the exec/load/store bits
  logic [31:0] bp_addr_q [BP_COUNT];
  logic [2:0]  bp_kind_q [BP_COUNT];
  logic        bp_en_q   [BP_COUNT];

  logic               halt_ack_q, step_ack_q, core_hold_q, trace_valid_q, ovf_q;
  logic [TRACE_W-1:0] trace_q;
  logic [3:0]         cause_q, idx_q;
  logic [31:0]        last_pc_q, cyc_q;

  logic               halt_ack_nxt, step_ack_nxt, core_hold_nxt, trace_valid_nxt, ovf_nxt;
  logic [TRACE_W-1:0] trace_nxt;
  logic [3:0]         cause_nxt, idx_nxt;

  logic       bp_hit;
  logic [3:0] bp_hit_idx;
  logic       bp_wr;
  logic       unused_kind_rsvd;

  assign bp_wr            = dbg.bp_valid && dbg.bp_write;
  assign unused_kind_rsvd = dbg.bp_kind[3];

  assign dbg.bp_ready    = 1'b1;
  assign dbg.halt_ack    = halt_ack_q;
  assign dbg.step_ack    = step_ack_q;
  assign dbg.core_hold   = core_hold_q;
  assign dbg.trace_valid = trace_valid_q;
  assign dbg.trace_data  = trace_q;

  // match every enabled slot against this cycle's retire and data access; lowest index wins
  always_comb begin
    bp_hit     = 1'b0;
    bp_hit_idx = '0;
    for (int i = BP_COUNT - 1; i >= 0; i--) begin
      if (bp_en_q[i] &&
          ((bp_kind_q[i][0] && dbg.retire_valid && dbg.retire_pc == bp_addr_q[i]) ||
           (dbg.mem_valid && dbg.mem_addr == bp_addr_q[i] &&
            (dbg.mem_write ? bp_kind_q[i][2] : bp_kind_q[i][1])))) begin
        bp_hit     = 1'b1;
        bp_hit_idx = 4'(i);
      end
    end
  end

  // slot programming; out-of-range indices are accepted and ignored
  always_ff @(posedge clk) begin
    for (int i = 0; i < BP_COUNT; i++) begin
      if (rst) begin
        bp_addr_q[i] <= '0;
        bp_kind_q[i] <= '0;
        bp_en_q[i]   <= 1'b0;
      end else if (bp_wr && dbg.bp_index == 8'(i)) begin
        bp_addr_q[i] <= dbg.bp_addr;
        bp_kind_q[i] <= dbg.bp_kind[2:0];
        bp_en_q[i]   <= dbg.bp_enable;
      end
    end
  end

  // free-running cycle counter and last retired PC for trace records
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      last_pc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (dbg.retire_valid) last_pc_q <= dbg.retire_pc;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_nxt;
  end

  // next-state: breakpoints only count in RUN; step beats run in HALTED
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RUN:       if (bp_hit || dbg.halt_req) state_nxt = S_HALT_PEND;
      S_HALT_PEND: if (dbg.core_quiesced) state_nxt = S_HALTED;
      S_HALTED: begin
        if (dbg.step_req)                        state_nxt = S_STEP;
        else if (dbg.run_req && !dbg.halt_req)   state_nxt = S_RUN;
      end
      S_STEP:      if (dbg.retire_valid) state_nxt = S_HALT_PEND;
      default:     state_nxt = S_RUN;
    endcase
  end

  // output next values: hold/ack follow the next state, trace captured on halt entry
  always_comb begin
    core_hold_nxt   = (state_nxt == S_HALT_PEND) || (state_nxt == S_HALTED);
    halt_ack_nxt    = (state_nxt == S_HALTED);
    step_ack_nxt    = (state_q == S_STEP) && dbg.retire_valid;
    cause_nxt       = cause_q;
    idx_nxt         = idx_q;
    trace_valid_nxt = trace_valid_q && !dbg.trace_ready;
    trace_nxt       = trace_q;
    ovf_nxt         = ovf_q;

    if (state_q == S_RUN && state_nxt == S_HALT_PEND) begin
      cause_nxt = bp_hit ? 4'd2 : 4'd1;
      idx_nxt   = bp_hit ? bp_hit_idx : 4'd0;
    end else if (step_ack_nxt) begin
      cause_nxt = 4'd3;
      idx_nxt   = 4'd0;
    end

    if (state_q == S_HALT_PEND && dbg.core_quiesced) begin
      if (trace_valid_nxt) begin
        ovf_nxt = 1'b1;
      end else begin
        trace_valid_nxt  = 1'b1;
        trace_nxt        = '0;
        trace_nxt[31:0]  = last_pc_q;
        trace_nxt[35:32] = cause_q;
        trace_nxt[39:36] = idx_q;
        trace_nxt[40]    = ovf_q;
        trace_nxt[95:64] = cyc_q;
        ovf_nxt          = 1'b0;
      end
    end
  end

  // output and trace registers
  always_ff @(posedge clk) begin
    if (rst) begin
      core_hold_q   <= RST_HOLD;
      halt_ack_q    <= 1'b0;
      step_ack_q    <= 1'b0;
      cause_q       <= 4'd1;
      idx_q         <= '0;
      trace_valid_q <= 1'b0;
      trace_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      core_hold_q   <= core_hold_nxt;
      halt_ack_q    <= halt_ack_nxt;
      step_ack_q    <= step_ack_nxt;
      cause_q       <= cause_nxt;
      idx_q         <= idx_nxt;
      trace_valid_q <= trace_valid_nxt;
      trace_q       <= trace_nxt;
      ovf_q         <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dbg_core_agent.sv
// Directed bench for dbg_core_agent: reset, halt/step/run, breakpoint table vectors, trace overflow, mid-step reset.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: trace_ready driven explicitly to exercise the one-entry buffer.
module tb_dbg_core_agent;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] cyc = '0;

  dbg_core_agent_if #(.TRACE_W(128)) bus ();

  dbg_core_agent #(.BP_COUNT(4), .TRACE_W(128), .RESET_HALTED(0)) dut (
    .clk (clk),
    .rst (rst),
    .dbg (bus)
  );

  always #5 clk = ~clk;

  // reference count of edges since reset release
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        mv;
    logic        mw;
    logic [31:0] ma;
    logic        hit;
    logic [3:0]  idx;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bp_prog(input logic wr, input logic [7:0] idx, input logic [31:0] addr,
                         input logic [3:0] kind, input logic en);
    bus.bp_valid  = 1'b1;
    bus.bp_write  = wr;
    bus.bp_index  = idx;
    bus.bp_addr   = addr;
    bus.bp_kind   = kind;
    bus.bp_enable = en;
    chk("bp_ready", 128'(bus.bp_ready), 128'd1);
    tick();
    bus.bp_valid = 1'b0;
    bus.bp_write = 1'b0;
  endtask

  task automatic quiesce();
    bus.core_quiesced = 1'b1;
    tick();
    bus.core_quiesced = 1'b0;
  endtask

  task automatic halt_by_req();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    quiesce();
  endtask

  task automatic drain(input string name);
    bus.trace_ready = 1'b1;
    tick();
    bus.trace_ready = 1'b0;
    chk(name, 128'(bus.trace_valid), 128'd0);
  endtask

  task automatic resume(input string name);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    chk(name, {126'd0, bus.halt_ack, bus.core_hold}, 128'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,  1'b1, 4'd2, 32'h1000}; // exec slot 2
    vecs[1] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h40, 1'b1, 4'd0, 32'h1000}; // store: slots 0,3 -> 0
    vecs[2] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h40, 1'b0, 4'd0, 32'h0};    // load on store watch
    vecs[3] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h80, 1'b1, 4'd1, 32'h1000}; // load watch slot 1
    vecs[4] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h80, 1'b0, 4'd0, 32'h0};    // store on load watch
    vecs[5] = '{1'b1, 32'h1004, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0};    // bp_write=0 ignored
    vecs[6] = '{1'b1, 32'h1000, 1'b1, 1'b1, 32'h40, 1'b1, 4'd0, 32'h1000}; // two hits, lowest wins
    vecs[7] = '{1'b1, 32'h3000, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0};    // index 5 write ignored
    vecs[8] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h40, 1'b0, 4'd0, 32'h0};    // mem_valid low

    bus.halt_req = 0; bus.run_req = 0; bus.step_req = 0;
    bus.bp_valid = 0; bus.bp_write = 0; bus.bp_index = '0; bus.bp_addr = '0;
    bus.bp_kind = '0; bus.bp_enable = 0; bus.trace_ready = 0;
    bus.core_quiesced = 0; bus.retire_valid = 0; bus.retire_pc = '0;
    bus.mem_valid = 0; bus.mem_write = 0; bus.mem_addr = '0;

    // reset values
    tick(); tick();
    chk("rst halt_ack",    128'(bus.halt_ack), 128'd0);
    chk("rst step_ack",    128'(bus.step_ack), 128'd0);
    chk("rst core_hold",   128'(bus.core_hold), 128'd0);
    chk("rst trace_valid", 128'(bus.trace_valid), 128'd0);
    chk("rst trace_data",  bus.trace_data, 128'd0);
    chk("rst bp_ready",    128'(bus.bp_ready), 128'd1);
    rst = 1'b0;
    tick();

    // halt request, quiesce three cycles later
    bus.halt_req = 1'b1;
    tick();
    chk("hreq hold", 128'(bus.core_hold), 128'd1);
    chk("hreq ack early", 128'(bus.halt_ack), 128'd0);
    tick(); tick();
    chk("hreq pend ack", 128'(bus.halt_ack), 128'd0);
    quiesce();
    bus.halt_req = 1'b0;
    chk("hreq halt_ack", 128'(bus.halt_ack), 128'd1);
    chk("hreq tvalid", 128'(bus.trace_valid), 128'd1);
    chk("hreq cause", 128'(bus.trace_data[35:32]), 128'd1);
    chk("hreq pc", 128'(bus.trace_data[31:0]), 128'd0);
    chk("hreq cycles", 128'(bus.trace_data[95:64]), 128'(cyc - 32'd1));
    chk("hreq upper zero", 128'(bus.trace_data[127:96]), 128'd0);
    tick();
    chk("hreq tvalid held", 128'(bus.trace_valid), 128'd1);
    drain("hreq drain");

    // single step from HALTED
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    chk("step hold", 128'(bus.core_hold), 128'd0);
    chk("step ack", 128'(bus.halt_ack), 128'd0);
    tick();
    chk("step wait hold", 128'(bus.core_hold), 128'd0);
    chk("step wait sack", 128'(bus.step_ack), 128'd0);
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h2004;
    tick();
    bus.retire_valid = 1'b0;
    chk("step sack", 128'(bus.step_ack), 128'd1);
    chk("step rehold", 128'(bus.core_hold), 128'd1);
    tick();
    chk("step sack pulse", 128'(bus.step_ack), 128'd0);
    quiesce();
    chk("step halt_ack", 128'(bus.halt_ack), 128'd1);
    chk("step cause", 128'(bus.trace_data[35:32]), 128'd3);
    chk("step pc", 128'(bus.trace_data[31:0]), 128'h2004);
    drain("step drain");
    resume("step resume");

    // program the table
    bp_prog(1'b1, 8'd2, 32'h1000, 4'b0001, 1'b1);
    bp_prog(1'b1, 8'd0, 32'h40,   4'b0100, 1'b1);
    bp_prog(1'b1, 8'd3, 32'h40,   4'b0100, 1'b1);
    bp_prog(1'b1, 8'd1, 32'h80,   4'b0010, 1'b1);
    bp_prog(1'b0, 8'd1, 32'h1004, 4'b0001, 1'b1);
    bp_prog(1'b1, 8'd5, 32'h3000, 4'b0001, 1'b1);

    for (int i = 0; i < 9; i++) begin
      bus.retire_valid = vecs[i].rv; bus.retire_pc = vecs[i].rpc;
      bus.mem_valid = vecs[i].mv; bus.mem_write = vecs[i].mw; bus.mem_addr = vecs[i].ma;
      tick();
      bus.retire_valid = 1'b0; bus.mem_valid = 1'b0;
      chk($sformatf("v%0d hold", i), 128'(bus.core_hold), 128'(vecs[i].hit));
      if (vecs[i].hit) begin
        quiesce();
        chk($sformatf("v%0d halt_ack", i), 128'(bus.halt_ack), 128'd1);
        chk($sformatf("v%0d cause", i), 128'(bus.trace_data[35:32]), 128'd2);
        chk($sformatf("v%0d idx", i), 128'(bus.trace_data[39:36]), 128'(vecs[i].idx));
        chk($sformatf("v%0d pc", i), 128'(bus.trace_data[31:0]), 128'(vecs[i].pc));
        chk($sformatf("v%0d ovf", i), 128'(bus.trace_data[40]), 128'd0);
        drain($sformatf("v%0d drain", i));
        resume($sformatf("v%0d resume", i));
        // resuming past the hit must not retrigger
        tick();
        chk($sformatf("v%0d no retrig", i), 128'(bus.core_hold), 128'd0);
      end
    end

    // overflow: two halts with ready low
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h1000;
    tick();
    bus.retire_valid = 1'b0;
    quiesce();
    chk("ovf first cause", 128'(bus.trace_data[35:32]), 128'd2);
    resume("ovf resume1");
    halt_by_req();
    chk("ovf second halted", 128'(bus.halt_ack), 128'd1);
    chk("ovf kept valid", 128'(bus.trace_valid), 128'd1);
    chk("ovf kept first", 128'(bus.trace_data[35:32]), 128'd2);
    drain("ovf drain1");
    resume("ovf resume2");
    halt_by_req();
    chk("ovf third bit40", 128'(bus.trace_data[40]), 128'd1);
    chk("ovf third cause", 128'(bus.trace_data[35:32]), 128'd1);
    drain("ovf drain2");
    resume("ovf resume3");
    halt_by_req();
    chk("ovf fourth bit40", 128'(bus.trace_data[40]), 128'd0);
    resume("ovf resume4");

    // reset while stepping with a record pending
    halt_by_req();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    chk("rs step hold", 128'(bus.core_hold), 128'd0);
    chk("rs step tvalid", 128'(bus.trace_valid), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs hold", 128'(bus.core_hold), 128'd0);
    chk("rs tvalid", 128'(bus.trace_valid), 128'd0);
    chk("rs tdata", bus.trace_data, 128'd0);
    chk("rs halt_ack", 128'(bus.halt_ack), 128'd0);
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h1000;
    bus.mem_valid = 1'b1; bus.mem_write = 1'b1; bus.mem_addr = 32'h40;
    tick();
    bus.retire_valid = 1'b0; bus.mem_valid = 1'b0;
    chk("rs slots cleared", 128'(bus.core_hold), 128'd0);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    chk("rs run halts", 128'(bus.core_hold), 128'd1);
    quiesce();
    chk("rs halt_ack", 128'(bus.halt_ack), 128'd1);
    chk("rs new cause", 128'(bus.trace_data[35:32]), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
